pc_fetch_seq: RTL and testbench
===============================

# pc_fetch_seq

Fetch-side PC sequencer for the five-stage MIPS pipeline. It owns the architectural fetch PC, issues instruction-memory requests over a req/ack handshake, and holds fetched instructions in a one-entry IF/ID output buffer under valid/ready flow control. It is the consumer of the next-PC selection: the ID-stage jump/branch target (j, jal, jr, jalr, beq-class, bgezal) arrives as one `redir_pc`. It applies that redirect with MIPS one-instruction delay-slot semantics and supplies PC+8 as the link value.

## Interface
- `RESET_PC`, 32'h0000_3000, first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `redir_valid`  in  1  ID stage requests a control transfer this cycle.
- `redir_pc`  in  32  target address, valid with `redir_valid`.
- `im_req`  out  1  instruction-memory request.
- `im_addr`  out  32  word address of the request.
- `im_ack`  in  1  memory accepts the request and returns data in the same cycle.
- `im_rdata`  in  32  instruction word, valid with `im_ack`.
- `if_valid`  out  1  output buffer holds an instruction.
- `if_ready`  in  1  IF/ID register accepts the instruction (low = stall).
- `if_instr`  out  32  buffered instruction.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc8`  out  32  `if_pc` + 8, the link value.
- `exc_adel`  out  1  buffered entry is a misaligned-fetch exception.

## Operation
- Registers: `npc_q` (next address to fetch), output buffer {valid, instr, pc, adel}, and FSM state.
- FSM states:
  - `S_BOOT`: entered on reset. Lasts one cycle after `reset_n` rises, `im_req`=0. Then goes to `S_REQ`.
  - `S_REQ`: `im_req`=1 whenever the buffer is empty or is being drained this cycle (`if_valid & if_ready`); otherwise `im_req`=0.
  - The FSM stays in `S_REQ`; buffer occupancy is the only flow state.
- Launch: a cycle with `im_req & im_ack`.
  - On launch, the buffer loads {1, `im_rdata`, `npc_q`, 0}.
  - `npc_q` advances to `npc_q`+4 unless a redirect is applied.
- Redirect: `redir_valid` loads `redir_pc` into `npc_q`, overriding the +4.
  - If it coincides with a launch, the launch still uses the old `npc_q`; that instruction is the delay slot. Only the following fetch uses `redir_pc`.
  - A redirect while no launch occurs overwrites `npc_q` directly. The already-buffered instruction is kept as the delay slot.
  - A second redirect before any launch overwrites the first; last one wins.
- Buffer drain: `if_valid & if_ready` with no same-cycle launch clears valid.
- `if_pc8` = `if_pc` + 32'd8, computed combinationally, modulo 2^32.
- +4 wraps modulo 2^32 with no flag.
- `im_addr` = `npc_q` at all times.

## Timing
- Reset values: `im_req` 0, `im_addr`/`if_pc` `RESET_PC`, `if_pc8` `RESET_PC`+8, `if_valid` 0, `if_instr` 0, `exc_adel` 0, state `S_BOOT`.
- Reset asserted mid-operation aborts any outstanding request immediately; no ack is awaited.
- `im_req` stays high and `im_addr` stays stable until `im_ack`. Wait states of any length are allowed.
- Latency: launch in cycle N gives `if_valid` in N+1.
- Throughput: one instruction per cycle with zero-wait memory and `if_ready` held high.
- Redirect to first target fetch: the redirect in cycle N makes `im_addr`=`redir_pc` in cycle N+1.
- Backpressure: when the buffer is full and `if_ready` is low, the buffer and `npc_q` are frozen and `im_req` is 0.
- A redirect arriving during a stall is still captured.

## Configuration
- `ALIGN_CHECK_EN` defined:
  - When `npc_q[1:0]` is nonzero, no memory request is issued.
  - When the buffer is free, it loads {1, 32'h0, `npc_q`, 1} and `exc_adel` goes high with that entry.
  - `npc_q` then holds until the next redirect.
- `ALIGN_CHECK_EN` undefined: `im_addr[1:0]` is forced to 0 and `exc_adel` is tied to 0.

## Structure
- Shared package `pc_pkg`: `RESET_PC` default, `PC_INC`=4, `LINK_OFS`=8, and the FSM state enum.
- Sub-module `pc_next_sel`: combinational next-`npc_q` choice, with redirect taking priority over +4 and +4 over hold.

## Test plan
- Reset and boot: hold `reset_n` low with `im_ack`=1, then release. Required: all outputs at reset values; `im_req`=0 for one cycle; `im_addr`=0x3000.
- Sequential stream: `im_ack`=1, `if_ready`=1. Required: `if_pc` is 0x3000, 0x3004, 0x3008 on consecutive cycles; `if_pc8`=0x3008 alongside `if_pc`=0x3000.
- Delay slot: `redir_valid` with `redir_pc`=0x3100 in the cycle 0x3004 launches. Required: the next `if_pc` values are 0x3004, then 0x3100.
- Stall: `if_ready`=0 for 3 cycles with the buffer full, plus a redirect to 0x3200 during the stall. Required: `if_instr` stable and `im_req`=0; after the stall, fetch resumes at 0x3200.
- Wait states: `im_ack` delayed 2 cycles. Required: `im_addr` stable for 3 cycles and exactly one instruction delivered.
- Misalignment: redirect to 0x3102. With `ALIGN_CHECK_EN`: `exc_adel`=1, `if_instr`=0, `if_pc`=0x3102, no request issued. Without it: fetch at 0x3100.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and FSM state type for the fetch-side PC sequencer.
package pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] LINK_OFS         = 32'd8;

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next fetch-address choice: redirect beats sequential +4, which beats hold.
module pc_next_sel
  import pc_pkg::*;
(
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        advance,
  input  logic [31:0] npc,
  output logic [31:0] npc_next
);

  always_comb begin
    npc_next = npc;
    if (redir_valid) begin
      npc_next = redir_pc;
    end else if (advance) begin
      npc_next = npc + PC_INC;
    end
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch PC sequencer with one-entry IF/ID buffer and delay-slot redirect.
// Optional misaligned-fetch exception enabled by defining ALIGN_CHECK_EN.
module pc_fetch_seq
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc8,
  output logic        exc_adel
);

  fetch_state_e state_q, state_d;
  logic [31:0]  npc_q, npc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         buf_free;
  logic         misaligned;
  logic [31:0]  fetch_addr;
  logic         req;
  logic         launch;
  logic         exc_load;

`ifdef ALIGN_CHECK_EN
  logic adel_q, adel_d;
  assign misaligned = |npc_q[1:0];
  assign fetch_addr = npc_q;
  assign exc_adel   = adel_q;
`else
  assign misaligned = 1'b0;
  assign fetch_addr = {npc_q[31:2], 2'b00};
  assign exc_adel   = 1'b0;
`endif

  always_comb begin
    buf_free = !valid_q || if_ready;
    req      = (state_q == S_REQ) && buf_free && !misaligned;
    launch   = req && im_ack;
    exc_load = (state_q == S_REQ) && buf_free && misaligned;
  end

  pc_next_sel u_next_sel (
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .advance     (launch),
    .npc         (npc_q),
    .npc_next    (npc_d)
  );

  // A launch refills the buffer even while it drains, giving one instruction per cycle.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
`ifdef ALIGN_CHECK_EN
    adel_d  = adel_q;
`endif
    if (launch) begin
      valid_d = 1'b1;
      instr_d = im_rdata;
      pc_d    = fetch_addr;
`ifdef ALIGN_CHECK_EN
      adel_d  = 1'b0;
`endif
    end else if (exc_load) begin
      valid_d = 1'b1;
      instr_d = 32'h0;
      pc_d    = npc_q;
`ifdef ALIGN_CHECK_EN
      adel_d  = 1'b1;
`endif
    end else if (valid_q && if_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = S_REQ;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      npc_q   <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= RESET_PC;
`ifdef ALIGN_CHECK_EN
      adel_q  <= 1'b0;
`endif
    end else begin
      npc_q   <= npc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
`ifdef ALIGN_CHECK_EN
      adel_q  <= adel_d;
`endif
    end
  end

  assign im_req   = req;
  assign im_addr  = fetch_addr;
  assign if_valid = valid_q;
  assign if_instr = instr_q;
  assign if_pc    = pc_q;
  assign if_pc8   = pc_q + LINK_OFS;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: boot, stream, delay slot, stall, wait states, misalignment.
module tb_pc_fetch_seq;

  logic        clk;
  logic        reset_n;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc8;
  logic        exc_adel;

  int errors = 0;
  int checks = 0;

  pc_fetch_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc8      (if_pc8),
    .exc_adel    (exc_adel)
  );

  // Memory returns a word tagged with the low half of its address.
  assign im_rdata = {16'hCAFE, im_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic ack, input logic rdy);
    redir_valid = rv;
    redir_pc    = rpc;
    im_ack      = ack;
    if_ready    = rdy;
    #1;
  endtask

  task automatic bootSequence();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("boot_req", {31'b0, im_req}, 32'd0);
    nextCycle();
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    #12;
    checkOutput("rst_req",   {31'b0, im_req},   32'd0);
    checkOutput("rst_addr",  im_addr,           32'h0000_3000);
    checkOutput("rst_pc",    if_pc,             32'h0000_3000);
    checkOutput("rst_pc8",   if_pc8,            32'h0000_3008);
    checkOutput("rst_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("rst_instr", if_instr,          32'h0);
    checkOutput("rst_adel",  {31'b0, exc_adel}, 32'd0);

    bootSequence();
    checkOutput("c1_req",   {31'b0, im_req},   32'd1);
    checkOutput("c1_addr",  im_addr,           32'h0000_3000);
    checkOutput("c1_valid", {31'b0, if_valid}, 32'd0);
    nextCycle();
    checkOutput("c2_pc",    if_pc,    32'h0000_3000);
    checkOutput("c2_pc8",   if_pc8,   32'h0000_3008);
    checkOutput("c2_instr", if_instr, 32'hCAFE_3000);
    checkOutput("c2_addr",  im_addr,  32'h0000_3004);
    nextCycle();
    checkOutput("c3_pc", if_pc, 32'h0000_3004);
    nextCycle();
    checkOutput("c4_pc",    if_pc,             32'h0000_3008);
    checkOutput("c4_valid", {31'b0, if_valid}, 32'd1);

    // Mid-run reset: request drops at once without waiting for an ack.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_req",   {31'b0, im_req},   32'd0);
    checkOutput("abort_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("abort_addr",  im_addr,           32'h0000_3000);
    bootSequence();
    checkOutput("d1_addr", im_addr, 32'h0000_3000);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_3100, 1'b1, 1'b1);
    checkOutput("d2_pc",   if_pc,             32'h0000_3000);
    checkOutput("d2_addr", im_addr,           32'h0000_3004);
    checkOutput("d2_req",  {31'b0, im_req},   32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("slot_pc",  if_pc,   32'h0000_3004);
    checkOutput("slot_adr", im_addr, 32'h0000_3100);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("tgt_pc",    if_pc,           32'h0000_3100);
    checkOutput("tgt_pc8",   if_pc8,          32'h0000_3108);
    checkOutput("stall1_req", {31'b0, im_req}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_3200, 1'b1, 1'b0);
    checkOutput("stall2_instr", if_instr,        32'hCAFE_3100);
    checkOutput("stall2_req",   {31'b0, im_req}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("stall3_instr", if_instr,        32'hCAFE_3100);
    checkOutput("stall3_req",   {31'b0, im_req}, 32'd0);
    checkOutput("stall3_pc",    if_pc,           32'h0000_3100);
    checkOutput("stall3_addr",  im_addr,         32'h0000_3200);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("resume_req", {31'b0, im_req}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("resume_pc", if_pc,   32'h0000_3200);
    checkOutput("ws1_addr",  im_addr, 32'h0000_3204);
    nextCycle();
    checkOutput("ws2_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("ws2_addr",  im_addr,           32'h0000_3204);
    checkOutput("ws2_req",   {31'b0, im_req},   32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("ws3_addr",  im_addr,           32'h0000_3204);
    checkOutput("ws3_valid", {31'b0, if_valid}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_3102, 1'b1, 1'b1);
    checkOutput("ws_valid", {31'b0, if_valid}, 32'd1);
    checkOutput("ws_pc",    if_pc,             32'h0000_3204);
    checkOutput("ws_instr", if_instr,          32'hCAFE_3204);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("mis_slot_pc", if_pc, 32'h0000_3208);
`ifdef ALIGN_CHECK_EN
    checkOutput("mis_req", {31'b0, im_req}, 32'd0);
    nextCycle();
    checkOutput("adel_flag",  {31'b0, exc_adel}, 32'd1);
    checkOutput("adel_instr", if_instr,          32'h0);
    checkOutput("adel_pc",    if_pc,             32'h0000_3102);
    checkOutput("adel_req",   {31'b0, im_req},   32'd0);
`else
    checkOutput("mis_addr", im_addr,         32'h0000_3100);
    checkOutput("mis_req",  {31'b0, im_req}, 32'd1);
    nextCycle();
    checkOutput("mis_pc",    if_pc,             32'h0000_3100);
    checkOutput("mis_instr", if_instr,          32'hCAFE_3100);
    checkOutput("mis_adel",  {31'b0, exc_adel}, 32'd0);
    checkOutput("mis_next",  im_addr,           32'h0000_3104);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
